// File: rtl/bcd_serial_addsub.sv
// -----------------------------------------------------------------------------
// bcd_serial_addsub
//
// Digit-serial packed-BCD adder/subtractor. One decimal digit is processed per
// clock, least significant digit first. Subtraction is done as
// a + nines_complement(b) + ~cin, so a borrow shows up as a missing decimal
// carry. When it borrows, the result is left in ten's complement form.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   start    : request a new operation; sampled only while ready=1
//   sub      : 0 = a+b+cin, 1 = a-b-cin
//   a, b     : packed BCD operands, digit 0 in bits [3:0]
//   cin      : carry-in (add) / borrow-in (subtract)
//   ready    : high only while idle
//   done     : one-cycle pulse when sum/cout/invalid have just been loaded
//   sum      : BCD result, held until the next done
//   cout     : decimal carry-out (add) / borrow-out (subtract)
//   invalid  : some captured operand digit was greater than 9
//   o_state  : current FSM state (0 = IDLE, 1 = RUN, 2 = DONE), for observation
//
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1. start is ignored at all other times and is never queued. The
// result is valid exactly in the cycle where done=1, DIGITS+1 rising edges
// after and including the accepting edge, and stays on the outputs until the
// next done or reset.
// -----------------------------------------------------------------------------
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  invalid,
    output logic [1:0]            o_state
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    // Operand shift registers: the digit being worked on is always in [3:0].
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;
    logic            r_c;
    logic [CW-1:0]   r_cnt;
    // Result digits enter at the top and shift down, so after DIGITS steps
    // digit 0 has arrived at [3:0].
    logic [W-1:0]    r_acc;
    logic            r_bad;

    logic [3:0]      w_a_d;
    logic [3:0]      w_b_raw;
    logic [3:0]      w_b_d;
    logic [4:0]      w_t;
    logic            w_gt9;
    logic [3:0]      w_digit;
    logic            w_bad;
    logic            w_last;
    logic            w_accept;
    logic [W+3:0]    w_cat;
    logic [W-1:0]    w_acc_next;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        ready   = 1'b0;
        done    = 1'b0;
        o_state = r_state;
        case (r_state)
            S_IDLE:  ready = 1'b1;
            S_DONE:  done  = 1'b1;
            default: begin
                ready = 1'b0;
                done  = 1'b0;
            end
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_CNT);

    // -------------------------------------------------------------------------
    // One-digit decimal adder
    // -------------------------------------------------------------------------
    assign w_a_d   = r_a[3:0];
    assign w_b_raw = r_b[3:0];
    // Nines complement, wrapping to 4 bits for non-decimal digits.
    assign w_b_d   = r_sub ? (4'd9 - w_b_raw) : w_b_raw;
    assign w_t     = {1'b0, w_a_d} + {1'b0, w_b_d} + {4'b0000, r_c};
    assign w_gt9   = (w_t > 5'd9);
    // (t + 6) mod 16 only depends on the low nibble of t.
    assign w_digit = w_gt9 ? (w_t[3:0] + 4'd6) : w_t[3:0];
    // The raw b digit is checked, not its complement.
    assign w_bad   = (w_a_d > 4'd9) || (w_b_raw > 4'd9);

    assign w_cat      = {w_digit, r_acc};
    assign w_acc_next = w_cat[W+3:4];

    // -------------------------------------------------------------------------
    // Datapath and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_bad   <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_sub <= sub;
            // Subtract needs the +1 of the ten's complement, less any borrow-in.
            r_c   <= sub ? ~cin : cin;
            r_cnt <= '0;
            r_acc <= '0;
            r_bad <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_a   <= r_a >> 4;
            r_b   <= r_b >> 4;
            r_c   <= w_gt9;
            r_cnt <= r_cnt + CW'(1);
            r_acc <= w_acc_next;
            r_bad <= r_bad | w_bad;
            if (w_last) begin
                sum     <= w_acc_next;
                // For subtract a missing final carry means a borrow.
                cout    <= r_sub ? ~w_gt9 : w_gt9;
                invalid <= r_bad | w_bad;
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_addsub
//
// Bench for bcd_serial_addsub (DIGITS=4). The driver issues operations and
// pushes the reference result into exp_q; a monitor on the falling edge pops
// and compares every time done is seen. The reference works on decimal
// integers for well-formed operands and on a per-digit rule otherwise.
// -----------------------------------------------------------------------------
module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int EW     = W + 2;
  localparam int P10    = 10 ** DIGITS;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          ready;
  logic          done;
  logic [W-1:0]  sum;
  logic          cout;
  logic          invalid;
  logic [1:0]    o_state;

  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .ready   (ready),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid),
    .o_state (o_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            checks = 0;
  int            errors = 0;
  int            n_acc  = 0;
  int            n_done = 0;
  logic [EW-1:0] held   = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] v);
    logic bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [EW-1:0] model(input logic s, input logic [W-1:0] av,
                                          input logic [W-1:0] bv, input logic c_in);
    logic [W-1:0] res = '0;
    logic         co  = 1'b0;
    logic         inv = has_bad(av) | has_bad(bv);
    int           r;
    if (!inv) begin
      if (s) begin
        r = bcd2int(av) - bcd2int(bv) - int'(c_in);
        co = (r < 0);
        if (r < 0) r = r + P10;
      end else begin
        r = bcd2int(av) + bcd2int(bv) + int'(c_in);
        co = (r >= P10);
        r = r % P10;
      end
      res = int2bcd(r);
    end else begin
      // Non-decimal digits: apply the digit rule literally.
      int c = s ? int'(!c_in) : int'(c_in);
      for (int i = 0; i < DIGITS; i++) begin
        int ad = int'(av[4*i +: 4]);
        int bd = int'(bv[4*i +: 4]);
        int t;
        int d;
        if (s) bd = (9 - bd) & 15;
        t = ad + bd + c;
        if (t > 9) begin
          d = (t + 6) % 16;
          c = 1;
        end else begin
          d = t;
          c = 0;
        end
        res[4*i +: 4] = 4'(d);
      end
      co = s ? (c == 0) : (c == 1);
    end
    return {res, co, inv};
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v = '0;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_ready(output bit ok);
    int waited = 0;
    @(negedge clk);
    while (!ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    ok = ready;
    if (!ok) chk("ready_timeout", 64'(ready), 64'd1);
  endtask

  task automatic do_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic c_in, input bit poke, output int t0);
    bit ok;
    wait_ready(ok);
    t0 = cyc;
    if (!ok) return;
    start = 1'b1;
    sub   = s;
    a     = av;
    b     = bv;
    cin   = c_in;
    exp_q.push_back(model(s, av, bv, c_in));
    acc_q.push_back(t0);
    n_acc++;
    @(negedge clk);
    chk("ready_low_in_run", 64'(ready), 64'd0);
    // Scramble inputs: the running operation must not see them.
    start = 1'b0;
    sub   = 1'($urandom);
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    if (poke) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      held = '0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        logic [EW-1:0] e;
        int            t0;
        e  = exp_q.pop_front();
        t0 = acc_q.pop_front();
        chk("sum", 64'(sum), 64'(e[EW-1:2]));
        chk("cout", 64'(cout), 64'(e[1]));
        chk("invalid", 64'(invalid), 64'(e[0]));
        chk("latency", 64'(cyc - t0), 64'(DIGITS + 1));
        n_done++;
      end
      held = {sum, cout, invalid};
    end else begin
      chk("result_hold", 64'({sum, cout, invalid}), 64'(held));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t1;
    int t2;
    int waited;
    bit ok;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_invalid", 64'(invalid), 64'd0);
    chk("rst_state", 64'(o_state), 64'd0);
    #2 rst_n = 1'b1;

    // Directed cases
    do_op(1'b0, 16'h9999, 16'h0001, 1'b0, 1'b0, t1);
    do_op(1'b0, 16'h0456, 16'h0789, 1'b1, 1'b0, t1);
    do_op(1'b1, 16'h0500, 16'h0123, 1'b0, 1'b0, t1);
    do_op(1'b1, 16'h0123, 16'h0500, 1'b0, 1'b0, t1);
    do_op(1'b0, 16'h00A0, 16'h0001, 1'b0, 1'b0, t1);
    do_op(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b1, t1);
    do_op(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, t1);

    // Reset in the second RUN cycle aborts the operation without a done.
    wait_ready(ok);
    if (ok) begin
      start = 1'b1;
      sub   = 1'b0;
      a     = 16'h0777;
      b     = 16'h0111;
      cin   = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ready", 64'(ready), 64'd1);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_sum", 64'(sum), 64'd0);
      chk("abort_cout", 64'(cout), 64'd0);
      chk("abort_invalid", 64'(invalid), 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("abort_no_pending", 64'(exp_q.size()), 64'd0);
    end

    // Back-to-back throughput
    do_op(1'b0, 16'h2468, 16'h1357, 1'b0, 1'b0, t1);
    do_op(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0, t2);
    chk("throughput", 64'(t2 - t1), 64'(DIGITS + 2));

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] av;
      logic [W-1:0] bv;
      av = ($urandom_range(0, 4) == 0) ? W'($urandom) : rand_bcd();
      bv = ($urandom_range(0, 4) == 0) ? W'($urandom) : rand_bcd();
      do_op(1'($urandom), av, bv, 1'($urandom), bit'($urandom_range(0, 1)), t1);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(n_done), 64'(n_acc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_serial_addsub.md
BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of packed BCD digits per operand (legal range 1..16).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; sampled only while ready=1.
REQ-005 SHALL have port sub, input, 1 bit: operation mode, 0 = a+b+cin, 1 = a-b-cin.
REQ-006 SHALL have port a, input, 4*DIGITS bits: operand A, digit 0 in bits [3:0].
REQ-007 SHALL have port b, input, 4*DIGITS bits: operand B, same packing as a.
REQ-008 SHALL have port cin, input, 1 bit: carry-in for add, borrow-in for subtract.
REQ-009 SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-011 SHALL have port sum, output, 4*DIGITS bits: BCD result.
REQ-012 SHALL have port cout, output, 1 bit: decimal carry-out for add, borrow-out for subtract.
REQ-013 SHALL have port invalid, output, 1 bit: at least one captured operand digit was greater than 9.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; IDLE -> RUN on start&ready; RUN lasts exactly DIGITS cycles; DONE lasts exactly 1 cycle.
REQ-015 SHALL, on start accepted, capture a, b, sub and cin into internal registers; later input changes SHALL NOT affect the running operation.
REQ-016 SHALL set the initial digit carry to cin when sub=0 and to ~cin when sub=1.
REQ-017 SHALL form the B digit as b_d when sub=0, and as (9 - b_d) truncated to 4 bits (nines complement) when sub=1.
REQ-018 SHALL process one digit per RUN cycle, LSD first, as t = a_d + b'_d + c (5-bit); if t>9 then digit = (t+6) mod 16 and c=1, otherwise digit = t and c=0.
REQ-019 SHALL, on entry to DONE, load sum with the digits computed in REQ-018, and load cout with c (add) or ~c (subtract).
REQ-020 SHALL, when a subtract borrows (cout=1), present sum as the ten's complement result: a - b - cin + 10^DIGITS.
REQ-021 SHALL set invalid on entry to DONE if any captured digit of a or b exceeds 9; sum and cout SHALL still follow REQ-018/019 bit-exactly.
REQ-022 SHALL hold sum, cout and invalid stable from DONE until the next DONE.
REQ-023 SHALL assert done only in the DONE state; first done SHALL be high in the cycle following DIGITS+1 rising edges after the accepting edge.
REQ-024 SHALL ignore start while ready=0, with no queuing.
REQ-025 SHALL accept a start on the cycle immediately after DONE (back-to-back throughput: one result every DIGITS+2 cycles).

Reset
REQ-026 SHALL, on rst_n low at any time including mid-RUN, immediately force state IDLE, ready=1, done=0, sum=0, cout=0, invalid=0, and clear all internal registers.
REQ-027 SHALL NOT produce a done for an operation aborted by reset.

Verification (DIGITS=4, values in BCD)
REQ-028 Add 9999 + 0001, cin=0 -> sum=0000, cout=1, invalid=0; done high exactly 5 edges after the accepting edge.
REQ-029 Add 0456 + 0789, cin=1 -> sum=1246, cout=0.
REQ-030 Subtract 0500 - 0123, cin=0 -> sum=0377, cout=0; subtract 0123 - 0500 -> sum=9623, cout=1.
REQ-031 a=0x00A0, b=0x0001, add -> invalid=1; next valid operation -> invalid=0.
REQ-032 Pulse rst_n low in the 2nd RUN cycle -> ready=1, sum=0, no done; start pulses during RUN are ignored (exactly one done per accepted start).
